// File: rtl/sap1_pkg.sv
// ============================================================================
// Module      : sap1_pkg
// Description : Shared widths, opcode type and opcode values for the SAP-1 datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sap1_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int OPCODE_WIDTH = 4;
  localparam int ADDR_WIDTH   = DATA_WIDTH - OPCODE_WIDTH;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;

  localparam opcode_t OP_LDA = 4'h0;
  localparam opcode_t OP_ADD = 4'h1;
  localparam opcode_t OP_SUB = 4'h2;
  localparam opcode_t OP_OUT = 4'hE;
  localparam opcode_t OP_HLT = 4'hF;

endpackage : sap1_pkg

`default_nettype wire

// File: rtl/sap1_tristate_buf.sv
// ============================================================================
// Module      : sap1_tristate_buf
// Description : Active-low enabled tri-state driver shared by every W-bus source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sap1_tristate_buf #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en_n,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_en_n ? {WIDTH{1'bz}} : i_d;

endmodule : sap1_tristate_buf

`default_nettype wire

// File: rtl/instruction_register.sv
// ============================================================================
// Module      : instruction_register
// Description : SAP-1 instruction register; captures the W-bus, presents the
//               opcode nibble and tri-states the operand nibble back onto the bus.
//               Optional macro IR_LOADED_FLAG_EN adds the 'loaded' output and
//               forces HLT on the opcode until the first load after reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_register #(
  parameter int DATA_WIDTH   = sap1_pkg::DATA_WIDTH,
  parameter int OPCODE_WIDTH = sap1_pkg::OPCODE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 load,
  inout  wire  [DATA_WIDTH-1:0]                w_bus,
  output logic [DATA_WIDTH-OPCODE_WIDTH-1:0]   address,
  output logic [OPCODE_WIDTH-1:0]              opcode
`ifdef IR_LOADED_FLAG_EN
  ,
  output logic                                 loaded
`endif
);

  localparam int ADDR_WIDTH = DATA_WIDTH - OPCODE_WIDTH;

  logic [DATA_WIDTH-1:0] r_ir;
  logic                  w_addr_en_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir <= '0;
    end else if (!load) begin
      r_ir <= w_bus;
    end
  end

  // Never drive the bus while something else is loading onto it, nor in reset.
  assign w_addr_en_n = enable | ~load | ~reset;

  sap1_tristate_buf #(
    .WIDTH (ADDR_WIDTH)
  ) u_addr_buf (
    .i_d    (r_ir[ADDR_WIDTH-1:0]),
    .i_en_n (w_addr_en_n),
    .o_y    (address)
  );

`ifdef IR_LOADED_FLAG_EN
  logic r_loaded;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_loaded <= 1'b0;
    end else if (!load) begin
      r_loaded <= 1'b1;
    end
  end

  // HLT until a real instruction has been captured since reset.
  assign opcode = r_loaded ? r_ir[DATA_WIDTH-1:ADDR_WIDTH] : {OPCODE_WIDTH{1'b1}};
  assign loaded = r_loaded;
`else
  assign opcode = r_ir[DATA_WIDTH-1:ADDR_WIDTH];
`endif

endmodule : instruction_register

`default_nettype wire

// File: tb/tb_instruction_register.sv
// ============================================================================
// Module      : tb_instruction_register
// Description : Self-checking bench for instruction_register against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_register;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic       bus_en;
  logic [7:0] bus_val;
  wire  [7:0] w_bus;
  wire  [3:0] address;
  wire  [3:0] opcode;
`ifdef IR_LOADED_FLAG_EN
  wire        loaded;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: the stored instruction byte and the "loaded since reset" fact.
  logic [7:0] m_ir     = 8'h00;
  bit         m_loaded = 1'b0;

  always #5 clk = ~clk;

  assign w_bus = bus_en ? bus_val : 8'bz;

  // An undriven address field reads as all-ones.
  pullup pu0 (address[0]);
  pullup pu1 (address[1]);
  pullup pu2 (address[2]);
  pullup pu3 (address[3]);

  instruction_register dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .load    (load),
    .w_bus   (w_bus),
    .address (address),
    .opcode  (opcode)
`ifdef IR_LOADED_FLAG_EN
    ,
    .loaded  (loaded)
`endif
  );

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_op;
    logic [7:0] exp_addr;
    exp_op = m_ir / 16;
`ifdef IR_LOADED_FLAG_EN
    if (!m_loaded) exp_op = 8'd15;
    cmp({tag, "_loaded"}, {7'd0, loaded}, {7'd0, m_loaded});
`endif
    if (reset === 1'b1 && load === 1'b1 && enable === 1'b0) exp_addr = m_ir % 16;
    else                                                    exp_addr = 8'h0F;
    cmp({tag, "_opcode"},  {4'd0, opcode},  exp_op);
    cmp({tag, "_address"}, {4'd0, address}, exp_addr);
  endtask

  // Apply inputs mid-cycle, check, take one rising edge, check again.
  task automatic step(input string tag, input logic rs, input logic ld, input logic en,
                      input logic drv, input logic [7:0] d);
    @(negedge clk);
    reset = rs; load = ld; enable = en; bus_en = drv; bus_val = d;
    if (!rs) begin m_ir = 8'h00; m_loaded = 1'b0; end
    #1 check_outputs({tag, "_mid"});
    @(posedge clk);
    if (rs && !ld) begin m_ir = d; m_loaded = 1'b1; end
    #1 check_outputs({tag, "_post"});
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; enable = 1'b1; bus_en = 1'b1; bus_val = 8'hAB;

    // Reset held with load requested: nothing captured, address released.
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b0, 1'b0, 1'b0, 1'b1, 8'hAB);

    step("load_AB", 1'b1, 1'b0, 1'b1, 1'b1, 8'hAB);
    cmp("load_AB_opA", {4'd0, opcode}, 8'h0A);

    step("oe_on",  1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cmp("oe_on_B", {4'd0, address}, 8'h0B);
    step("oe_off", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 5; i++) step("hold_5C", 1'b1, 1'b1, 1'b1, 1'b1, 8'h5C);
    cmp("hold_opA", {4'd0, opcode}, 8'h0A);

    // Load and enable together: load wins, no self-drive.
    step("both_3E", 1'b1, 1'b0, 1'b0, 1'b1, 8'h3E);
    cmp("both_op3", {4'd0, opcode}, 8'h03);
    step("after_both", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cmp("after_both_E", {4'd0, address}, 8'h0E);

    // Asynchronous reset pulse between edges.
    step("reload_AB", 1'b1, 1'b0, 1'b1, 1'b1, 8'hAB);
    @(negedge clk);
    load = 1'b1; enable = 1'b0; bus_en = 1'b0;
    #2 reset = 1'b0; m_ir = 8'h00; m_loaded = 1'b0;
    #1 check_outputs("async_rst");
    #1 reset = 1'b1;
    #1 check_outputs("async_rel");

    // Reset release immediately followed by a load.
    step("rst_again", 1'b0, 1'b0, 1'b1, 1'b1, 8'h71);
    step("first_load", 1'b1, 1'b0, 1'b1, 1'b1, 8'h71);

    for (int i = 0; i < 60; i++) begin
      logic       rs, ld, en, drv;
      logic [7:0] d;
      rs  = ($urandom_range(0, 15) != 0);
      ld  = $urandom_range(0, 1) == 1;
      en  = $urandom_range(0, 1) == 1;
      drv = !ld || ($urandom_range(0, 1) == 1);
      d   = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 14))};
      step("rand", rs, ld, en, drv, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_instruction_register

`default_nettype wire
